// File: rtl/spi_instr_decoder_if.sv
// Bridge and register-file signals seen by the SPI instruction decoder.
// slave = decoder side, master = bridge / register-file side.
interface spi_instr_decoder_if #(
  parameter int ADDR_W = 6
) ();
  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              addr_err;

  modport slave (
    input  byte_sync, data_in, reg_rdata,
    output data_out, reg_addr, reg_wdata, reg_we, reg_re, addr_err
  );

  modport master (
    output byte_sync, data_in, reg_rdata,
    input  data_out, reg_addr, reg_wdata, reg_we, reg_re, addr_err
  );
endinterface

// File: rtl/spi_instr_decoder.sv
// Turns the SPI bridge byte stream (command byte + data bytes) into
// register-file write/read strobes, with optional address auto-increment.
module spi_instr_decoder #(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_n,
  spi_instr_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_CMD     = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_RD_DATA = 2'd2
  } state_e;

  state_e            state_r, state_nxt_s;
  logic [2:0]        cs_sync_r;
  logic              armed_r;
  logic              frame_active_s, accept_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic              ai_r, ai_nxt_s;
  logic              rd_pend_r, rd_pend_nxt_s;
  logic [ADDR_W-1:0] reg_addr_r, reg_addr_nxt_s;
  logic [7:0]        reg_wdata_r, reg_wdata_nxt_s;
  logic              reg_we_r, reg_we_nxt_s;
  logic              reg_re_r, reg_re_nxt_s;
  logic [7:0]        data_out_r, data_out_nxt_s;
  logic              addr_err_r, addr_err_nxt_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS));
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic ai);
    return a + {{(ADDR_W-1){1'b0}}, ai};
  endfunction

  // A frame only counts once cs has been seen inactive since reset, so a
  // reset in mid-frame never turns the remaining bytes into a command.
  assign frame_active_s = ~cs_sync_r[2] & armed_r;
  assign accept_s       = bus.byte_sync & frame_active_s;

  // cs_n synchroniser and re-arm tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_r <= 3'b000;
      armed_r   <= 1'b0;
    end else begin
      cs_sync_r <= {cs_sync_r[1:0], cs_n};
      armed_r   <= armed_r | cs_sync_r[2];
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    ai_nxt_s        = ai_r;
    rd_pend_nxt_s   = 1'b0;
    reg_addr_nxt_s  = reg_addr_r;
    reg_wdata_nxt_s = reg_wdata_r;
    reg_we_nxt_s    = 1'b0;
    reg_re_nxt_s    = 1'b0;
    data_out_nxt_s  = data_out_r;
    addr_err_nxt_s  = addr_err_r;

    if (!frame_active_s) begin
      state_nxt_s    = ST_CMD;
      data_out_nxt_s = 8'h00;
    end else begin
      // reg_re_r is high only if the pending read was in range
      if (rd_pend_r) begin
        data_out_nxt_s = reg_re_r ? bus.reg_rdata : 8'h00;
      end else begin
        data_out_nxt_s = data_out_r;
      end

      case (state_r)
        ST_CMD: begin
          data_out_nxt_s = 8'h00;
          if (accept_s) begin
            ai_nxt_s = bus.data_in[6];
            if (bus.data_in[7]) begin
              state_nxt_s = ST_WR_DATA;
              addr_nxt_s  = bus.data_in[ADDR_W-1:0];
            end else begin
              state_nxt_s    = ST_RD_DATA;
              rd_pend_nxt_s  = 1'b1;
              reg_addr_nxt_s = bus.data_in[ADDR_W-1:0];
              reg_re_nxt_s   = in_range(bus.data_in[ADDR_W-1:0]);
              addr_err_nxt_s = addr_err_r | ~in_range(bus.data_in[ADDR_W-1:0]);
              addr_nxt_s     = next_addr(bus.data_in[ADDR_W-1:0], bus.data_in[6]);
            end
          end else begin
            state_nxt_s = ST_CMD;
          end
        end
        ST_WR_DATA: begin
          if (accept_s) begin
            reg_addr_nxt_s  = addr_r;
            reg_wdata_nxt_s = bus.data_in;
            reg_we_nxt_s    = in_range(addr_r);
            addr_err_nxt_s  = addr_err_r | ~in_range(addr_r);
            addr_nxt_s      = next_addr(addr_r, ai_r);
          end else begin
            addr_nxt_s = addr_r;
          end
        end
        ST_RD_DATA: begin
          if (accept_s) begin
            rd_pend_nxt_s  = 1'b1;
            reg_addr_nxt_s = addr_r;
            reg_re_nxt_s   = in_range(addr_r);
            addr_err_nxt_s = addr_err_r | ~in_range(addr_r);
            addr_nxt_s     = next_addr(addr_r, ai_r);
          end else begin
            addr_nxt_s = addr_r;
          end
        end
        default: begin
          state_nxt_s = ST_CMD;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_CMD;
      addr_r      <= '0;
      ai_r        <= 1'b0;
      rd_pend_r   <= 1'b0;
      reg_addr_r  <= '0;
      reg_wdata_r <= 8'h00;
      reg_we_r    <= 1'b0;
      reg_re_r    <= 1'b0;
      data_out_r  <= 8'h00;
      addr_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      ai_r        <= ai_nxt_s;
      rd_pend_r   <= rd_pend_nxt_s;
      reg_addr_r  <= reg_addr_nxt_s;
      reg_wdata_r <= reg_wdata_nxt_s;
      reg_we_r    <= reg_we_nxt_s;
      reg_re_r    <= reg_re_nxt_s;
      data_out_r  <= data_out_nxt_s;
      addr_err_r  <= addr_err_nxt_s;
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.reg_addr  = reg_addr_r;
  assign bus.reg_wdata = reg_wdata_r;
  assign bus.reg_we    = reg_we_r;
  assign bus.reg_re    = reg_re_r;
  assign bus.addr_err  = addr_err_r;

endmodule

// File: tb/tb_spi_instr_decoder.sv
// Directed bench for spi_instr_decoder: emulates the SPI bridge and a
// register file, logs strobes and compares against hand-computed values.
module tb_spi_instr_decoder;

  logic clk;
  logic rst_n;
  logic cs_n;
  logic [7:0] mem [0:63];
  logic [7:0] m0, m1, m2;

  int n_checks;
  int n_fail;
  int excl_cnt;
  logic [5:0] we_addr_q [$];
  logic [7:0] we_data_q [$];
  logic [5:0] re_addr_q [$];

  spi_instr_decoder_if #(.ADDR_W(6)) bus ();

  spi_instr_decoder #(.ADDR_W(6), .NUM_REGS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cs_n  (cs_n),
    .bus   (bus.slave)
  );

  assign bus.reg_rdata = mem[bus.reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe logger, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.reg_we) begin
      we_addr_q.push_back(bus.reg_addr);
      we_data_q.push_back(bus.reg_wdata);
    end
    if (bus.reg_re) re_addr_q.push_back(bus.reg_addr);
    if (bus.reg_we && bus.reg_re) excl_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
  endtask

  task automatic check_we(input string tag, input int idx, input logic [5:0] a, input logic [7:0] d);
    if (we_addr_q.size() > idx) begin
      check_val({tag, "_addr"}, 32'(we_addr_q[idx]), 32'(a));
      check_val({tag, "_data"}, 32'(we_data_q[idx]), 32'(d));
    end else begin
      check_val({tag, "_missing"}, 32'(we_addr_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_re(input string tag, input int idx, input logic [5:0] a);
    if (re_addr_q.size() > idx) begin
      check_val(tag, 32'(re_addr_q[idx]), 32'(a));
    end else begin
      check_val({tag, "_missing"}, 32'(re_addr_q.size()), 32'(idx + 1));
    end
  endtask

  // one byte: MISO value is what data_out holds when the byte starts
  task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
    @(negedge clk);
    miso = bus.data_out;
    repeat (8) @(negedge clk);
    bus.data_in   = b;
    bus.byte_sync = 1'b1;
    @(negedge clk);
    bus.byte_sync = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    excl_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[5]  = 8'hA1;
    mem[6]  = 8'hB2;
    mem[7]  = 8'hC3;
    mem[20] = 8'hEE;
    rst_n = 1'b0;
    cs_n = 1'b1;
    bus.byte_sync = 1'b0;
    bus.data_in = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_data_out", 32'(bus.data_out), 32'h0);
    check_val("rst_reg_addr", 32'(bus.reg_addr), 32'h0);
    check_val("rst_reg_wdata", 32'(bus.reg_wdata), 32'h0);
    check_val("rst_reg_we", 32'(bus.reg_we), 32'h0);
    check_val("rst_reg_re", 32'(bus.reg_re), 32'h0);
    check_val("rst_addr_err", 32'(bus.addr_err), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // single write, no auto-increment
    clear_logs();
    frame_start();
    send_byte(8'h83, m0);
    send_byte(8'h5A, m1);
    frame_end();
    check_val("wr1_count", 32'(we_addr_q.size()), 32'd1);
    check_we("wr1", 0, 6'd3, 8'h5A);
    check_val("wr1_err", 32'(bus.addr_err), 32'h0);
    check_val("wr1_no_re", 32'(re_addr_q.size()), 32'd0);

    // burst write with auto-increment
    clear_logs();
    frame_start();
    send_byte(8'hC2, m0);
    send_byte(8'h11, m0);
    send_byte(8'h22, m0);
    send_byte(8'h33, m0);
    frame_end();
    check_val("burst_count", 32'(we_addr_q.size()), 32'd3);
    check_we("burst0", 0, 6'd2, 8'h11);
    check_we("burst1", 1, 6'd3, 8'h22);
    check_we("burst2", 2, 6'd4, 8'h33);

    // read with auto-increment
    clear_logs();
    frame_start();
    send_byte(8'h45, m0);
    send_byte(8'h00, m1);
    send_byte(8'h00, m2);
    frame_end();
    check_val("rd_miso0", 32'(m0), 32'h00);
    check_val("rd_miso1", 32'(m1), 32'hA1);
    check_val("rd_miso2", 32'(m2), 32'hB2);
    check_val("rd_re_count", 32'(re_addr_q.size()), 32'd3);
    check_re("rd_re0", 0, 6'd5);
    check_re("rd_re1", 1, 6'd6);
    check_re("rd_re2", 2, 6'd7);
    check_val("rd_no_we", 32'(we_addr_q.size()), 32'd0);
    check_val("rd_idle_data_out", 32'(bus.data_out), 32'h00);

    // out-of-range write, then the flag survives a valid frame
    clear_logs();
    frame_start();
    send_byte(8'h94, m0);
    send_byte(8'hFF, m0);
    frame_end();
    check_val("oor_wr_no_we", 32'(we_addr_q.size()), 32'd0);
    check_val("oor_wr_err", 32'(bus.addr_err), 32'h1);
    clear_logs();
    frame_start();
    send_byte(8'h81, m0);
    send_byte(8'h07, m0);
    frame_end();
    check_we("after_oor", 0, 6'd1, 8'h07);
    check_val("oor_err_sticky", 32'(bus.addr_err), 32'h1);

    // out-of-range read returns zero without a read strobe
    clear_logs();
    frame_start();
    send_byte(8'h14, m0);
    send_byte(8'h00, m1);
    frame_end();
    check_val("oor_rd_miso", 32'(m1), 32'h00);
    check_val("oor_rd_no_re", 32'(re_addr_q.size()), 32'd0);

    // reset in mid-frame: rest of the frame is ignored
    clear_logs();
    frame_start();
    send_byte(8'h83, m0);
    rst_n = 1'b0;
    #1;
    check_val("midrst_err_clr", 32'(bus.addr_err), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send_byte(8'h55, m0);
    frame_end();
    check_val("midrst_no_we", 32'(we_addr_q.size()), 32'd0);

    // auto-increment wrap past 63
    clear_logs();
    frame_start();
    send_byte(8'hFF, m0);
    send_byte(8'h01, m0);
    send_byte(8'h02, m0);
    frame_end();
    check_val("wrap_count", 32'(we_addr_q.size()), 32'd1);
    check_we("wrap", 0, 6'd0, 8'h02);
    check_val("wrap_err", 32'(bus.addr_err), 32'h1);

    // early frame end after the command byte
    clear_logs();
    frame_start();
    send_byte(8'h81, m0);
    frame_end();
    check_val("early_no_we", 32'(we_addr_q.size()), 32'd0);
    check_val("early_no_re", 32'(re_addr_q.size()), 32'd0);
    frame_start();
    send_byte(8'h81, m0);
    send_byte(8'h07, m0);
    frame_end();
    check_val("early_next_count", 32'(we_addr_q.size()), 32'd1);
    check_we("early_next", 0, 6'd1, 8'h07);

    check_val("strobe_excl", 32'(excl_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
